// File: rtl/mig_calib_supervisor.sv
// MIG calibration supervisor: sequences the reset timer enable, waits for
// MIG release and a stable calibration, then releases user logic. Calibration
// timeout or loss re-runs the MIG reset with bounded retries, then faults.
module mig_calib_supervisor #(
  parameter int unsigned SYNC_STAGES          = 2,
  parameter int unsigned CALIB_TIMEOUT_CYCLES = 10000000,
  parameter int unsigned TIMEOUT_WIDTH        = 24,
  parameter int unsigned SETTLE_CYCLES        = 256,
  parameter int unsigned BACKOFF_CYCLES       = 16,
  parameter int unsigned MAX_RETRIES          = 3,
  parameter int unsigned RETRY_WIDTH          = 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Mig_Reset_Released,
  input  logic                   i_Calib_Complete,
  output logic                   o_Timer_Enable,
  output logic                   o_User_Reset,
  output logic                   o_Ready,
  output logic                   o_Fault,
  output logic [RETRY_WIDTH-1:0] o_Retry_Count
);

  localparam int unsigned SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned BACKOFF_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

  localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST     = TIMEOUT_WIDTH'(CALIB_TIMEOUT_CYCLES - 1);
  localparam logic [SETTLE_W-1:0]      SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [BACKOFF_W-1:0]     BACKOFF_LAST = BACKOFF_W'(BACKOFF_CYCLES - 1);
  localparam logic [RETRY_WIDTH-1:0]   RETRY_MAX    = RETRY_WIDTH'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_RELEASE,
    S_WAIT_CALIB,
    S_SETTLE,
    S_READY,
    S_BACKOFF,
    S_FAULT
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [SYNC_STAGES-1:0]   cal_sync;
  logic                     cal_s;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
  logic [SETTLE_W-1:0]      settle_cnt;
  logic [BACKOFF_W-1:0]     backoff_cnt;
  logic                     timed_out;
  logic                     retry_path;
  logic                     retry_inc;
  logic                     timer_enable_d;
  logic                     ready_d;
  logic                     fault_d;

  assign cal_s     = cal_sync[SYNC_STAGES-1];
  assign timed_out = (tmo_cnt >= TMO_LAST);

  // Synchronize the asynchronous calibration-complete status
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cal_sync <= '0;
    end else begin
      cal_sync <= {cal_sync[SYNC_STAGES-2:0], i_Calib_Complete};
    end
  end

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, retry decision and output decode of the current state
  always_comb begin
    state_next     = state;
    retry_path     = 1'b0;
    retry_inc      = 1'b0;
    timer_enable_d = 1'b0;
    ready_d        = 1'b0;
    fault_d        = 1'b0;
    case (state)
      S_IDLE: state_next = S_WAIT_RELEASE;
      S_WAIT_RELEASE: begin
        timer_enable_d = 1'b1;
        if (i_Mig_Reset_Released) state_next = S_WAIT_CALIB;
        else if (timed_out)       retry_path = 1'b1;
      end
      S_WAIT_CALIB: begin
        timer_enable_d = 1'b1;
        if (cal_s)          state_next = S_SETTLE;
        else if (timed_out) retry_path = 1'b1;
      end
      S_SETTLE: begin
        timer_enable_d = 1'b1;
        if (!cal_s)                         state_next = S_WAIT_CALIB;
        else if (settle_cnt == SETTLE_LAST) state_next = S_READY;
      end
      S_READY: begin
        timer_enable_d = 1'b1;
        ready_d        = 1'b1;
        if (!cal_s) retry_path = 1'b1;
      end
      S_BACKOFF: begin
        if (backoff_cnt == BACKOFF_LAST) state_next = S_WAIT_RELEASE;
      end
      S_FAULT: fault_d = 1'b1;
      default: state_next = S_IDLE;
    endcase
    if (retry_path) begin
      if (o_Retry_Count < RETRY_MAX) begin
        retry_inc  = 1'b1;
        state_next = S_BACKOFF;
      end else begin
        state_next = S_FAULT;
      end
    end
  end

  // Timeout counter: runs from WAIT_RELEASE entry through WAIT_CALIB and
  // SETTLE without clearing, saturating instead of wrapping
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT_RELEASE || state == S_WAIT_CALIB || state == S_SETTLE) begin
      if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Settle and backoff counters: zero outside their state, so zero on entry
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      settle_cnt  <= '0;
      backoff_cnt <= '0;
    end else begin
      settle_cnt  <= (state == S_SETTLE)  ? settle_cnt + SETTLE_W'(1)   : '0;
      backoff_cnt <= (state == S_BACKOFF) ? backoff_cnt + BACKOFF_W'(1) : '0;
    end
  end

  // Retry count: bumped on each transition into BACKOFF, bounded by RETRY_MAX
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Retry_Count <= '0;
    end else if (retry_inc) begin
      o_Retry_Count <= o_Retry_Count + RETRY_WIDTH'(1);
    end
  end

  // Registered outputs; ready and user reset come from one decode so they
  // always move on the same edge
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      o_Timer_Enable <= 1'b0;
      o_User_Reset   <= 1'b1;
      o_Ready        <= 1'b0;
      o_Fault        <= 1'b0;
    end else begin
      o_Timer_Enable <= timer_enable_d;
      o_User_Reset   <= ~ready_d;
      o_Ready        <= ready_d;
      o_Fault        <= fault_d;
    end
  end

endmodule

// File: tb/tb_mig_calib_supervisor.sv
// Directed bench for mig_calib_supervisor with small timing parameters.
module tb_mig_calib_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       rel;
  logic       cal;
  logic       te;
  logic       ur;
  logic       rdy;
  logic       flt;
  logic [1:0] rcnt;

  int tests = 0;
  int fails = 0;
  int e     = 0;

  mig_calib_supervisor #(
    .SYNC_STAGES(2),
    .CALIB_TIMEOUT_CYCLES(100),
    .TIMEOUT_WIDTH(24),
    .SETTLE_CYCLES(8),
    .BACKOFF_CYCLES(4),
    .MAX_RETRIES(2),
    .RETRY_WIDTH(2)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .i_Mig_Reset_Released(rel),
    .i_Calib_Complete(cal),
    .o_Timer_Enable(te),
    .o_User_Reset(ur),
    .o_Ready(rdy),
    .o_Fault(flt),
    .o_Retry_Count(rcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rel = 1'b0;
    cal = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    e   = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    tests++;
    if ({te, ur, rdy, flt, rcnt} !== 6'b010000) begin
      fails++;
      $display("FAIL reset_outputs: got te/ur/rdy/flt/rc=%b required 010000", {te, ur, rdy, flt, rcnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_ready_latency();
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) rel = 1'b1;
      if (i == 20) cal = 1'b1;
      tick();
      if (e >= 2) begin
        tests++;
        if (te !== 1'b1) begin
          fails++;
          $display("FAIL lat_timer_enable e%0d: got %b required 1", e, te);
        end
      end
      if (e == 30) begin
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL lat_ready_early e30: got %b required 0", rdy);
        end
      end
      if (e == 31) begin
        tests++;
        if ({rdy, ur, rcnt} !== 4'b1000) begin
          fails++;
          $display("FAIL lat_ready e31: got rdy/ur/rc=%b required 1000", {rdy, ur, rcnt});
        end
      end
    end
  endtask

  task automatic test_settle_glitch();
    do_reset();
    rel = 1'b1;
    for (int i = 1; i <= 23; i++) begin
      if (i == 5)  cal = 1'b1;
      if (i == 11) cal = 1'b0;
      if (i == 12) cal = 1'b1;
      tick();
      if (e == 16 || e == 22) begin
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL glitch_ready_early e%0d: got %b required 0", e, rdy);
        end
      end
      if (e == 23) begin
        tests++;
        if ({rdy, ur} !== 2'b10) begin
          fails++;
          $display("FAIL glitch_ready e23: got rdy/ur=%b required 10", {rdy, ur});
        end
      end
    end
  endtask

  task automatic test_timeout_retry();
    do_reset();
    rel = 1'b1;
    for (int i = 1; i <= 122; i++) begin
      if (i == 111) cal = 1'b1;
      tick();
      case (e)
        100: begin
          tests++;
          if (rcnt !== 2'd0) begin
            fails++;
            $display("FAIL tmo_retry_before e100: got %0d required 0", rcnt);
          end
        end
        101: begin
          tests++;
          if ({te, rcnt} !== 3'b101) begin
            fails++;
            $display("FAIL tmo_retry_step e101: got te/rc=%b required 101", {te, rcnt});
          end
        end
        102, 105: begin
          tests++;
          if (te !== 1'b0) begin
            fails++;
            $display("FAIL tmo_backoff_low e%0d: got %b required 0", e, te);
          end
        end
        106: begin
          tests++;
          if (te !== 1'b1) begin
            fails++;
            $display("FAIL tmo_backoff_end e106: got %b required 1", te);
          end
        end
        121: begin
          tests++;
          if (rdy !== 1'b0) begin
            fails++;
            $display("FAIL tmo_ready_early e121: got %b required 0", rdy);
          end
        end
        122: begin
          tests++;
          if ({rdy, rcnt} !== 3'b101) begin
            fails++;
            $display("FAIL tmo_ready e122: got rdy/rc=%b required 101", {rdy, rcnt});
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_fault();
    do_reset();
    rel = 1'b1;
    for (int i = 1; i <= 330; i++) begin
      if (i == 311) cal = 1'b1;
      tick();
      if (e == 309) begin
        tests++;
        if ({flt, rcnt} !== 3'b010) begin
          fails++;
          $display("FAIL fault_before e309: got flt/rc=%b required 010", {flt, rcnt});
        end
      end
      if (e == 310 || e == 330) begin
        tests++;
        if ({flt, te, ur, rdy, rcnt} !== 6'b101010) begin
          fails++;
          $display("FAIL fault_state e%0d: got flt/te/ur/rdy/rc=%b required 101010", e, {flt, te, ur, rdy, rcnt});
        end
      end
    end
  endtask

  task automatic test_calib_loss();
    do_reset();
    rel = 1'b1;
    cal = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      if (i == 16) cal = 1'b0;
      tick();
      if (e == 11) begin
        tests++;
        if (rdy !== 1'b0) begin
          fails++;
          $display("FAIL loss_ready_early e11: got %b required 0", rdy);
        end
      end
      if (e == 12 || e == 18) begin
        tests++;
        if ({rdy, ur} !== 2'b10) begin
          fails++;
          $display("FAIL loss_ready_held e%0d: got rdy/ur=%b required 10", e, {rdy, ur});
        end
      end
      if (e == 17) begin
        tests++;
        if (rcnt !== 2'd0) begin
          fails++;
          $display("FAIL loss_retry_before e17: got %0d required 0", rcnt);
        end
      end
      if (e == 19) begin
        tests++;
        if ({rdy, ur, te, rcnt} !== 5'b01001) begin
          fails++;
          $display("FAIL loss_drop e19: got rdy/ur/te/rc=%b required 01001", {rdy, ur, te, rcnt});
        end
      end
    end
  endtask

  task automatic test_reset_in_backoff();
    do_reset();
    rel = 1'b1;
    cal = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 16) cal = 1'b0;
      tick();
    end
    tests++;
    if ({te, rcnt} !== 3'b001) begin
      fails++;
      $display("FAIL rst_bo_precond e20: got te/rc=%b required 001", {te, rcnt});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({te, ur, rdy, flt, rcnt} !== 6'b010000) begin
      fails++;
      $display("FAIL rst_bo_outputs: got te/ur/rdy/flt/rc=%b required 010000", {te, ur, rdy, flt, rcnt});
    end
    tick();
    tests++;
    if (te !== 1'b0) begin
      fails++;
      $display("FAIL rst_bo_idle: got te=%b required 0", te);
    end
    tick();
    tests++;
    if ({te, rcnt} !== 3'b100) begin
      fails++;
      $display("FAIL rst_bo_restart: got te/rc=%b required 100", {te, rcnt});
    end
  endtask

  task automatic test_reset_in_fault();
    do_reset();
    rel = 1'b1;
    for (int i = 1; i <= 312; i++) tick();
    tests++;
    if ({flt, rcnt} !== 3'b110) begin
      fails++;
      $display("FAIL rst_ft_precond: got flt/rc=%b required 110", {flt, rcnt});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({te, ur, rdy, flt, rcnt} !== 6'b010000) begin
      fails++;
      $display("FAIL rst_ft_outputs: got te/ur/rdy/flt/rc=%b required 010000", {te, ur, rdy, flt, rcnt});
    end
    tick();
    tick();
    tests++;
    if ({te, flt} !== 2'b10) begin
      fails++;
      $display("FAIL rst_ft_restart: got te/flt=%b required 10", {te, flt});
    end
  endtask

  initial begin
    rst = 1'b1;
    rel = 1'b0;
    cal = 1'b0;
    test_reset();
    test_ready_latency();
    test_settle_glitch();
    test_timeout_retry();
    test_fault();
    test_calib_loss();
    test_reset_in_backoff();
    test_reset_in_fault();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
